// File: rtl/mdclcg_pkg.sv
// Shared defaults and FSM encoding for the multiply-by-shift-add LCG
// state controller.
package mdclcg_pkg;

  localparam int unsigned MDCLCG_WIDTH = 64;
  localparam int unsigned MDCLCG_SH1   = 0;
  localparam int unsigned MDCLCG_SH2   = 16;
  localparam int unsigned MDCLCG_INC   = 1;

  typedef enum logic {
    ST_UNSEEDED = 1'b0,
    ST_RUN      = 1'b1
  } mdclcg_st_e;

endpackage

// File: rtl/mdclcg_state_ctrl.sv
// LCG state register, seed/advance FSM and valid/ready sample port;
// the three-operand adder lives beside this block.
module mdclcg_state_ctrl
  import mdclcg_pkg::*;
#(
  parameter int unsigned WIDTH = MDCLCG_WIDTH,
  parameter int unsigned SH1   = MDCLCG_SH1,
  parameter int unsigned SH2   = MDCLCG_SH2,
  parameter int unsigned INC   = MDCLCG_INC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic [WIDTH:0]   sum_in,
  input  logic             cout_in,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] op_c,
  output logic             cin,
  output logic [WIDTH-1:0] rand_out,
  output logic             rand_valid,
  input  logic             rand_ready,
  output logic             wrap,
  output logic             seeded,
  output logic [31:0]      sample_cnt
);

  mdclcg_st_e       st_q, st_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             advance;
  logic             accept;

  assign op_a = state_q << SH1;
  assign op_b = state_q << SH2;
  assign op_c = WIDTH'(INC);
  assign cin  = 1'b0;

  assign advance = (st_q == ST_RUN) && en && !seed_load &&
                   (!valid_q || rand_ready);
  assign accept  = valid_q && rand_ready;

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    rout_d  = rout_q;
    valid_d = valid_q;
    wrap_d  = wrap_q;
    cnt_d   = cnt_q;
    if (seed_load) begin
      st_d    = ST_RUN;
      state_d = seed;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      if (accept) begin
        cnt_d   = cnt_q + 32'd1;
        valid_d = 1'b0;
      end
      if (advance) begin
        state_d = sum_in[WIDTH-1:0];
        rout_d  = sum_in[WIDTH-1:0];
        valid_d = 1'b1;
        wrap_d  = sum_in[WIDTH] | cout_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_UNSEEDED;
      state_q <= '0;
      rout_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rout_q  <= rout_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rand_out   = rout_q;
  assign rand_valid = valid_q;
  assign wrap       = wrap_q;
  assign seeded     = (st_q == ST_RUN);
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_mdclcg_state_ctrl.sv
// Directed bench for mdclcg_state_ctrl with a behavioural
// three-operand adder wired beside the DUT.
module tb_mdclcg_state_ctrl;

  logic        clk;
  logic        rst_n;
  logic        seed_load;
  logic [63:0] seed;
  logic        en;
  logic [64:0] sum_in;
  logic        cout_in;
  logic [63:0] op_a, op_b, op_c;
  logic        cin;
  logic [63:0] rand_out;
  logic        rand_valid;
  logic        rand_ready;
  logic        wrap;
  logic        seeded;
  logic [31:0] sample_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [65:0] wide_sum;

  mdclcg_state_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed       (seed),
    .en         (en),
    .sum_in     (sum_in),
    .cout_in    (cout_in),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_c       (op_c),
    .cin        (cin),
    .rand_out   (rand_out),
    .rand_valid (rand_valid),
    .rand_ready (rand_ready),
    .wrap       (wrap),
    .seeded     (seeded),
    .sample_cnt (sample_cnt)
  );

  always_comb begin
    wide_sum = {2'b00, op_a} + {2'b00, op_b} + {2'b00, op_c}
             + {65'd0, cin};
    sum_in   = wide_sum[64:0];
    cout_in  = wide_sum[65];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " rand_out"}, rand_out, 64'd0);
    chk({tag, " rand_valid"}, 64'(rand_valid), 64'd0);
    chk({tag, " wrap"}, 64'(wrap), 64'd0);
    chk({tag, " seeded"}, 64'(seeded), 64'd0);
    chk({tag, " sample_cnt"}, 64'(sample_cnt), 64'd0);
    chk({tag, " op_a"}, op_a, 64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    seed_load  = 1'b0;
    seed       = '0;
    en         = 1'b0;
    rand_ready = 1'b0;
    #12;
    chk_zero("reset");
    chk("cin", 64'(cin), 64'd0);
    chk("op_c", op_c, 64'd1);
    #1 rst_n = 1'b1;

    en = 1'b1;
    rand_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("unseeded valid", 64'(rand_valid), 64'd0);
    chk("unseeded seeded", 64'(seeded), 64'd0);

    seed_load = 1'b1;
    seed = 64'd1;
    step();
    seed_load = 1'b0;
    chk("seed seeded", 64'(seeded), 64'd1);
    chk("seed state", op_a, 64'd1);
    chk("seed op_b", op_b, 64'h1_0000);
    chk("seed valid", 64'(rand_valid), 64'd0);
    step();
    chk("s1 valid", 64'(rand_valid), 64'd1);
    chk("s1 out", rand_out, 64'h1_0002);
    chk("s1 wrap", 64'(wrap), 64'd0);
    chk("s1 cnt", 64'(sample_cnt), 64'd0);
    step();
    chk("s2 out", rand_out, 64'h1_0003_0003);
    chk("s2 cnt", 64'(sample_cnt), 64'd1);
    en = 1'b0;
    step();
    chk("s2 acc cnt", 64'(sample_cnt), 64'd2);
    chk("s2 acc valid", 64'(rand_valid), 64'd0);

    for (int i = 0; i < 10; i++) begin
      step();
      chk("en0 state", op_a, 64'h1_0003_0003);
      chk("en0 valid", 64'(rand_valid), 64'd0);
    end

    en = 1'b1;
    rand_ready = 1'b0;
    seed_load = 1'b1;
    seed = 64'd1;
    step();
    seed_load = 1'b0;
    chk("bp seed cnt", 64'(sample_cnt), 64'd0);
    step();
    chk("bp s1 out", rand_out, 64'h1_0002);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp hold out", rand_out, 64'h1_0002);
      chk("bp hold state", op_a, 64'h1_0002);
      chk("bp hold valid", 64'(rand_valid), 64'd1);
      chk("bp hold cnt", 64'(sample_cnt), 64'd0);
    end
    rand_ready = 1'b1;
    step();
    chk("bp resume out", rand_out, 64'h1_0003_0003);
    chk("bp resume cnt", 64'(sample_cnt), 64'd1);

    seed_load = 1'b1;
    seed = 64'h1234;
    step();
    seed_load = 1'b0;
    en = 1'b0;
    chk("reseed valid", 64'(rand_valid), 64'd0);
    chk("reseed cnt", 64'(sample_cnt), 64'd0);
    chk("reseed state", op_a, 64'h1234);

    seed_load = 1'b1;
    seed = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    seed_load = 1'b0;
    en = 1'b1;
    chk("ovf op_b", op_b, 64'hFFFF_FFFF_FFFF_0000);
    step();
    chk("ovf out", rand_out, 64'hFFFF_FFFF_FFFF_0000);
    chk("ovf wrap", 64'(wrap), 64'd1);
    step();
    chk("ovf cnt", 64'(sample_cnt), 64'd1);
    chk("ovf valid", 64'(rand_valid), 64'd1);

    #3 rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("postrst valid", 64'(rand_valid), 64'd0);
    end
    chk("postrst seeded", 64'(seeded), 64'd0);

    seed_load = 1'b1;
    seed = 64'd1;
    step();
    seed_load = 1'b0;
    step();
    chk("postrst s1 out", rand_out, 64'h1_0002);
    chk("postrst s1 valid", 64'(rand_valid), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdclcg_state_ctrl.md
MDCLCG_STATE_CTRL -- requirements
Module: mdclcg_state_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64: state, operand and sample width.
REQ-002 The block SHALL have parameter SH1, default 0: first multiplier shift, so operand A = state << SH1.
REQ-003 The block SHALL have parameter SH2, default 16: second multiplier shift, so operand B = state << SH2 and multiplier = 2^SH1 + 2^SH2.
REQ-004 The block SHALL have parameter INC, default 1: additive increment, driven as operand C.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset; every port below SHALL be present.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- seed_load  in  1  load seed into state
- seed  in  WIDTH  seed value
- en  in  1  permit state advance
- sum_in  in  WIDTH+1  sum returned by the three-operand adder (combinational path)
- cout_in  in  1  adder carry-out
- op_a, op_b, op_c  out  WIDTH  adder operands
- cin  out  1  adder carry-in, constant 0
- rand_out  out  WIDTH  generated sample
- rand_valid  out  1  sample valid
- rand_ready  in  1  consumer accepts sample
- wrap  out  1  sample produced with adder overflow
- seeded  out  1  state holds a valid seed
- sample_cnt  out  32  accepted-sample count

Function
REQ-006 op_a, op_b and op_c SHALL be combinational from the state register, truncated to WIDTH bits; op_c = INC and cin = 0 always.
REQ-007 The FSM SHALL have two states: UNSEEDED (after reset) and RUN; seeded = 1 only in RUN.
REQ-008 UNSEEDED: operands are don't-care, no advance occurs and rand_valid = 0.
REQ-009 seed_load = 1 at any edge SHALL set state to seed, clear rand_valid and wrap, enter RUN and take priority over advance and handshake.
REQ-010 Advance condition: RUN and en = 1 and seed_load = 0 and (rand_valid = 0 or rand_ready = 1).
REQ-011 On advance, state and rand_out SHALL both take sum_in[WIDTH-1:0], rand_valid SHALL be set to 1 and wrap SHALL take sum_in[WIDTH] OR cout_in; the next value is therefore x(n+1) = (x(n) * (2^SH1 + 2^SH2) + INC) mod 2^WIDTH.
REQ-012 A sample SHALL be accepted when rand_valid = 1 and rand_ready = 1; without advance in the same cycle, rand_valid SHALL clear.
REQ-013 While rand_valid = 1 and rand_ready = 0, rand_out, wrap and state SHALL hold, regardless of en.
REQ-014 Latency: seed_load at edge k gives state = seed after k; with en = 1 the first sample is valid after edge k+1; with rand_ready held at 1, one sample per cycle follows.
REQ-015 sample_cnt SHALL increment by 1 on each accepted sample, wrap from 2^32-1 to 0, and clear on seed_load; an acceptance coinciding with seed_load SHALL NOT count.
REQ-016 The block SHALL NOT check sum_in against any internal model; sum_in is trusted.

Reset
REQ-017 Asserting rst_n = 0 SHALL asynchronously force UNSEEDED, state = 0, rand_out = 0, rand_valid = 0, wrap = 0 and sample_cnt = 0; the block SHALL operate normally from the first rising edge after deassertion.
REQ-018 Reset mid-stream SHALL discard any pending sample with no acceptance counted.

Structure
REQ-019 A shared mdclcg_pkg SHALL hold the default WIDTH, SH1, SH2 and INC and the FSM state enum.
REQ-020 The block SHALL be a single module with no sub-modules; the adder is instantiated beside it at the level above, op_* feeding the adder and the adder's sum and carry feeding sum_in and cout_in.

Verification
REQ-021 Reset, then seed_load with seed = 1, en = 1, rand_ready = 1 -> samples 0x10002, then 0x1_0003_0003; sample_cnt = 2.
REQ-022 seed = 0xFFFF_FFFF_FFFF_FFFF, en = 1 -> rand_out = 0xFFFF_FFFF_FFFF_0000 and wrap = 1.
REQ-023 Backpressure: rand_ready = 0 for 5 cycles after the first sample -> rand_out is stable at 0x10002, state is unchanged and sample_cnt is unchanged; releasing rand_ready resumes with 0x1_0003_0003.
REQ-024 seed_load asserted while rand_valid = 1 and rand_ready = 1 -> rand_valid = 0 next cycle, sample_cnt = 0, state = new seed.
REQ-025 en = 0 in RUN with rand_valid = 0 -> no sample is produced; the state is held for 10 cycles.
REQ-026 rst_n pulsed low asynchronously mid-stream -> all outputs are 0 immediately; no sample is produced until a new seed_load.
